// File: rtl/count_button_ctrl.sv
// Push-button front end: synchronise, debounce and strobe each button, then
// turn button 0 into run/pause (short press) and clear (long press) controls.
module count_button_lane #(
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int LONG_PRESS_CYCLES = 25000000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Level,
  output logic o_Press,
  output logic o_Release,
  output logic o_Long,
  output logic long_seen,
  output logic press_nxt,
  output logic release_nxt,
  output logic long_nxt
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES - 1);

  logic          sync1, sync2, flip;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;

  // The next-cycle strobes are exported so the control FSM can act on the
  // same edge the registered strobes appear.
  assign flip        = (sync2 != o_Level) && (db_cnt == DB_MAX);
  assign press_nxt   = flip && !o_Level;
  assign release_nxt = flip && o_Level;
  assign long_nxt    = o_Level && !flip && !long_seen && (hold_cnt == HOLD_MAX);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      db_cnt    <= '0;
      hold_cnt  <= '0;
      o_Level   <= 1'b0;
      o_Press   <= 1'b0;
      o_Release <= 1'b0;
      o_Long    <= 1'b0;
      long_seen <= 1'b0;
    end else begin
      sync1     <= i_Switch;
      sync2     <= sync1;
      if (sync2 == o_Level || flip) db_cnt <= '0;
      else                          db_cnt <= db_cnt + DW'(1);
      o_Level   <= o_Level ^ flip;
      o_Press   <= press_nxt;
      o_Release <= release_nxt;
      o_Long    <= long_nxt;
      // Saturates one short of the threshold; long_seen blocks a repeat.
      if (!o_Level)                 hold_cnt <= '0;
      else if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
      if (press_nxt)     long_seen <= 1'b0;
      else if (long_nxt) long_seen <= 1'b1;
    end
  end
endmodule

module count_button_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int LONG_PRESS_CYCLES = 25000000,
  parameter int NUM_BTN           = 4
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [NUM_BTN-1:0] i_Switch,
  output logic [NUM_BTN-1:0] o_Level,
  output logic [NUM_BTN-1:0] o_Press,
  output logic [NUM_BTN-1:0] o_Release,
  output logic [NUM_BTN-1:0] o_Long,
  output logic               o_Run,
  output logic               o_Clear
);
  typedef enum logic {IDLE, HELD} state_t;

  logic [NUM_BTN-1:0] long_seen, press_nxt, release_nxt, long_nxt;
  logic               ctrl_unused;
  state_t             state, state_nxt;
  logic               run_nxt, clear_nxt;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_lane
    count_button_lane #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_lane (
      .i_Clk      (i_Clk),
      .i_Rst      (i_Rst),
      .i_Switch   (i_Switch[b]),
      .o_Level    (o_Level[b]),
      .o_Press    (o_Press[b]),
      .o_Release  (o_Release[b]),
      .o_Long     (o_Long[b]),
      .long_seen  (long_seen[b]),
      .press_nxt  (press_nxt[b]),
      .release_nxt(release_nxt[b]),
      .long_nxt   (long_nxt[b])
    );
  end

  // Only button 0 drives control; the other lanes' internals stay local.
  assign ctrl_unused = ^{long_seen, press_nxt, release_nxt, long_nxt};

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state   <= IDLE;
      o_Run   <= 1'b0;
      o_Clear <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_Run   <= run_nxt;
      o_Clear <= clear_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = o_Run;
    clear_nxt = 1'b0;
    case (state)
      IDLE: if (press_nxt[0]) state_nxt = HELD;
      HELD: begin
        if (long_nxt[0]) begin
          clear_nxt = 1'b1;
          run_nxt   = 1'b0;
        end
        if (release_nxt[0]) begin
          state_nxt = IDLE;
          if (!long_seen[0]) run_nxt = !o_Run;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: doc/count_button_ctrl.md
# count_button_ctrl

Debounces the board's raw push-buttons and turns them into clean control events. It sits directly upstream of the 1 Hz two-digit display counter, which consumes `o_Run` as its count enable and `o_Clear` as its digit clear. The block also gives generic per-button level, press, release and long-press strobes for other consumers. Button 0 is the stopwatch button: a short press toggles run/pause, and a long press clears.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive cycles an input must hold a new value before it is accepted (10 ms at 25 MHz). Must be ≥ 2.
- `LONG_PRESS_CYCLES`, default 25000000: cycles a debounced press must persist before it is a long press (1 s). Must be ≥ 1.
- `NUM_BTN`, default 4: number of buttons. Must be ≥ 1.
- `i_Clk`  in  1: single clock for all logic.
- `i_Rst`  in  1: reset, asynchronous, active-high.
- `i_Switch`  in  NUM_BTN: raw button inputs, 1 = pressed, asynchronous to `i_Clk`.
- `o_Level`  out  NUM_BTN: debounced button level.
- `o_Press`  out  NUM_BTN: one-cycle strobe on a debounced 0→1 edge.
- `o_Release`  out  NUM_BTN: one-cycle strobe on a debounced 1→0 edge.
- `o_Long`  out  NUM_BTN: one-cycle strobe when a press reaches `LONG_PRESS_CYCLES`.
- `o_Run`  out  1: count enable for the display counter.
- `o_Clear`  out  1: one-cycle clear strobe for the display counter.

## Operation
- **Synchronizer:** each button has a 2-flop synchronizer (`sync1`, `sync2`). Its reset value is 0.
- **Debounce, per button:**
  - The counter is `$clog2(DEBOUNCE_CYCLES)` bits wide.
  - When `sync2 == o_Level`, the counter is cleared.
  - Otherwise the counter increments.
  - On the `DEBOUNCE_CYCLES`-th consecutive mismatch cycle (the counter equals `DEBOUNCE_CYCLES-1` and there is a mismatch), `o_Level` flips and the counter clears.
  - Any single matching cycle restarts the count, so glitches shorter than `DEBOUNCE_CYCLES` are rejected.
- **Edge strobes:** `o_Press` and `o_Release` are registered together with `o_Level`. They are high exactly in the first cycle that `o_Level` shows its new value.
- **Hold counter, per button:**
  - Cleared while `o_Level` = 0 and on the press cycle.
  - Increments each cycle while `o_Level` = 1.
  - Saturates after the long event.
- **Long-press strobe:**
  - `o_Long` pulses once, exactly `LONG_PRESS_CYCLES` cycles after the `o_Press` cycle, and only while the press is still held.
  - A per-button `long_seen` flag sets with `o_Long` and clears on the press cycle.
- **Button 0 control FSM, states IDLE and HELD:**
  - IDLE → HELD on `o_Press[0]`.
  - In HELD, if `o_Long[0]` fires: `o_Clear` = 1 for that cycle and `o_Run` is forced to 0 on the same edge. The FSM stays in HELD.
  - HELD → IDLE on `o_Release[0]`. If `long_seen[0]` = 0, `o_Run` toggles on that edge; otherwise `o_Run` is unchanged.
- Buttons 1..NUM_BTN-1 affect only their own generic outputs and never touch `o_Run` or `o_Clear`.

## Timing
- **Reset values:** every output is 0, along with all synchronizer flops, counters, `long_seen` flags and the FSM (IDLE). Outputs go to 0 asynchronously on `i_Rst` assertion.
- **Debounce latency:** if the raw input changes and is first sampled at edge 0, `o_Level`, `o_Press` and `o_Release` update at edge `DEBOUNCE_CYCLES+1`.
- **Long-press latency:** `o_Long` fires `LONG_PRESS_CYCLES` edges after the `o_Press` edge.
- **Control latency:**
  - `o_Run` toggles on the same edge as `o_Release[0]`.
  - `o_Clear` is coincident with `o_Long[0]`.
- **Reset mid-hold:** a button still held when `i_Rst` deasserts is treated as a new press. `o_Press` arrives `DEBOUNCE_CYCLES+2` edges after deassertion, and no `o_Release` is generated for the interrupted press.
- **Simultaneous events:** buttons are fully independent, so strobes on different bits may coincide. `o_Press` and `o_Release` on the same bit can never coincide, and neither can `o_Long` and `o_Release`.
- **Release before long:** releasing before `LONG_PRESS_CYCLES` suppresses `o_Long` entirely.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=16, `NUM_BTN`=4.
- **Reset:** assert `i_Rst` with `i_Switch`=4'b1111 → all outputs 0 and held 0 throughout reset.
- **Short press:**
  - Stimulus: `i_Switch[0]` rises, held 10 cycles, then released.
  - `o_Level[0]`=1 and `o_Press[0]` pulse at edge 5 after the first sampling edge.
  - `o_Release[0]` pulses 5 edges after the release is sampled.
  - `o_Run` goes 0→1 on the release edge; `o_Long` and `o_Clear` stay 0.
  - A second identical press returns `o_Run` to 0.
- **Bounce rejection:**
  - Stimulus: `i_Switch[1]` toggles with high/low runs of 3 cycles for 30 cycles, then settles high.
  - `o_Level[1]` stays 0 during the bounce.
  - Exactly one `o_Press[1]` pulse occurs, 5 edges after settling.
- **Long press:**
  - Stimulus: with `o_Run`=1, hold `i_Switch[0]` for 40 cycles.
  - `o_Long[0]` and `o_Clear` pulse once, 16 edges after `o_Press[0]`, and `o_Run` goes to 0.
  - On release, `o_Release[0]` pulses and `o_Run` stays 0.
- **Simultaneous buttons:** `i_Switch[2]` and `i_Switch[3]` rise on the same cycle → `o_Press[2]` and `o_Press[3]` pulse on the same edge, and `o_Run` and `o_Clear` are unaffected.
- **Reset mid-hold:**
  - Stimulus: assert `i_Rst` 8 cycles into a button-0 hold, keep the button held, deassert reset.
  - Outputs clear immediately when reset asserts.
  - `o_Press[0]` pulses 6 edges after deassertion.
  - `o_Run` stays 0 until the next release.
